// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Brief    : Run/step/halt sequencer for the single-cycle CPU datapath.
//            Gates the datapath clock-enable, holds the core in reset, and
//            counts committed instructions.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int          PC_W       = 32,
    parameter int          CNT_W      = 32,
    parameter int          RST_CYCLES = 4,
    parameter logic [31:0] HALT_INST  = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic [31:0]      inst,
    output logic             cpu_en,
    output logic             core_rst,
    output logic             halted,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [1:0] c_ST_RESET  = 2'd0;
    localparam logic [1:0] c_ST_HALTED = 2'd1;
    localparam logic [1:0] c_ST_RUN    = 2'd2;
    localparam logic [1:0] c_ST_STEP   = 2'd3;

    localparam logic [1:0] c_CAUSE_NONE = 2'd0;
    localparam logic [1:0] c_CAUSE_USER = 2'd1;
    localparam logic [1:0] c_CAUSE_BP   = 2'd2;
    localparam logic [1:0] c_CAUSE_HI   = 2'd3;

    localparam int                c_RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_RC_W-1:0] c_RST_LAST = c_RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]        r_state;
    logic [c_RC_W-1:0] r_rst_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_cause;
    logic              r_skip;
    logic              r_step_q;
    logic              r_core_rst;
    logic              r_halted;

    logic       w_hi;
    logic       w_bp;
    logic       w_step_edge;
    logic       w_en;
    logic [1:0] w_nstate;
    logic [1:0] w_ncause;
    logic       w_nskip;

    assign w_hi        = (inst == HALT_INST);
    assign w_bp        = bp_en & (pc == bp_addr) & ~r_skip;
    assign w_step_edge = step_req & ~r_step_q;

    always_comb begin
        w_nstate = r_state;
        w_ncause = r_cause;
        w_nskip  = r_skip;
        w_en     = 1'b0;
        case (r_state)
            c_ST_RESET: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_nstate = c_ST_HALTED;
                    w_ncause = c_CAUSE_NONE;
                end
            end
            c_ST_HALTED: begin
                // halt_req wins over both resume sources in the same cycle
                if (halt_req) begin
                    w_nstate = c_ST_HALTED;
                end else if (run_req) begin
                    w_nstate = c_ST_RUN;
                    w_nskip  = 1'b1;
                end else if (w_step_edge) begin
                    w_nstate = c_ST_STEP;
                    w_nskip  = 1'b1;
                end
            end
            c_ST_RUN: begin
                w_en    = ~(w_hi | w_bp | halt_req);
                w_nskip = 1'b0;
                if (w_hi) begin
                    w_nstate = c_ST_HALTED;
                    w_ncause = c_CAUSE_HI;
                end else if (w_bp) begin
                    w_nstate = c_ST_HALTED;
                    w_ncause = c_CAUSE_BP;
                end else if (halt_req) begin
                    w_nstate = c_ST_HALTED;
                    w_ncause = c_CAUSE_USER;
                end
            end
            c_ST_STEP: begin
                w_en     = ~w_hi;
                w_nskip  = 1'b0;
                w_nstate = c_ST_HALTED;
                w_ncause = w_hi ? c_CAUSE_HI : c_CAUSE_NONE;
            end
            default: begin
                w_nstate = c_ST_RESET;
            end
        endcase
    end

    // No commit can happen in a cycle where reset is being applied
    assign cpu_en = w_en & ~clrn;

    always_ff @(posedge clk) begin
        if (clrn) begin
            r_state    <= c_ST_RESET;
            r_rst_cnt  <= '0;
            r_cnt      <= '0;
            r_cause    <= c_CAUSE_NONE;
            r_skip     <= 1'b0;
            r_step_q   <= 1'b1;
            r_core_rst <= 1'b1;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_nstate;
            r_cause    <= w_ncause;
            r_skip     <= w_nskip;
            r_step_q   <= step_req;
            r_core_rst <= (w_nstate == c_ST_RESET);
            r_halted   <= (w_nstate == c_ST_HALTED);
            if ((r_state == c_ST_RESET) && (r_rst_cnt != c_RST_LAST)) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end
            if (cpu_en && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign core_rst   = r_core_rst;
    assign halted     = r_halted;
    assign state      = r_state;
    assign halt_cause = r_cause;
    assign instr_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Brief    : Scoreboard bench for cpu_run_ctrl with a datapath PC model and a
//            mode-level reference model; directed scenarios then random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int          RSTC = 4;

    logic        clk = 1'b0;
    logic        clrn = 1'b1, run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = '0, pc = '0, inst = '0;
    logic        cpu_en, core_rst, halted;
    logic [1:0]  state, halt_cause;
    logic [3:0]  instr_cnt;

    cpu_run_ctrl #(.PC_W(32), .CNT_W(4), .RST_CYCLES(RSTC), .HALT_INST(HALT)) dut (
        .clk(clk), .clrn(clrn), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .inst(inst), .cpu_en(cpu_en), .core_rst(core_rst), .halted(halted),
        .state(state), .halt_cause(halt_cause), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic       crst;
        logic       hlt;
        logic [1:0] st;
        logic [1:0] cause;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    // Reference model: mode 0=reset 1=halted 2=run 3=step
    bit          m_valid = 0;
    int          m_mode = 0, m_rst_left = 0, m_cnt = 0, m_cause = 0;
    bit          m_skip = 0, m_stepq = 1;
    logic [31:0] m_pc = '0;
    bit          bpe = 0, halt_on = 0;
    logic [31:0] bpa = '0, halt_pc = '0;

    task automatic cyc(input bit c, input bit r, input bit h, input bit s);
        bit hi, bp, en, edge_s;
        @(posedge clk); #1;
        cyc_no++;
        clrn = c; run_req = r; halt_req = h; step_req = s;
        bp_en = bpe; bp_addr = bpa; pc = m_pc;
        inst = (halt_on && m_pc == halt_pc) ? HALT : ($urandom() & 32'h7FFF_FFFF);
        hi = (inst == HALT);
        bp = bpe && (m_pc == bpa) && !m_skip;
        en = 0;
        if (!c && m_mode == 2) en = !(hi || bp || h);
        if (!c && m_mode == 3) en = !hi;
        if (m_valid)
            q.push_back('{en: en, crst: (m_mode == 0), hlt: (m_mode == 1),
                          st: 2'(m_mode), cause: 2'(m_cause), cnt: 4'(m_cnt)});
        // datapath: PC cleared while core held in reset, +4 per commit
        if (m_valid && m_mode == 0) m_pc = '0;
        else if (en) m_pc = m_pc + 4;
        if (c) begin
            m_valid = 1; m_mode = 0; m_rst_left = RSTC; m_cnt = 0;
            m_cause = 0; m_skip = 0; m_stepq = 1;
        end else if (m_valid) begin
            edge_s = s && !m_stepq;
            m_stepq = s;
            if (en) m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
            if (m_mode == 0) begin
                m_rst_left--;
                if (m_rst_left == 0) begin m_mode = 1; m_cause = 0; end
            end else if (m_mode == 1) begin
                if (!h && (r || edge_s)) begin m_mode = r ? 2 : 3; m_skip = 1; end
            end else if (m_mode == 2) begin
                m_skip = 0;
                if (hi || bp || h) begin
                    m_mode = 1;
                    m_cause = hi ? 3 : (bp ? 2 : 1);
                end
            end else begin
                m_skip = 0; m_mode = 1; m_cause = hi ? 3 : 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0);
        idle(RSTC + 1);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_no);
        end
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    // Monitor: every cycle the DUT presents a full output set to the scoreboard
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{en: cpu_en, crst: core_rst, hlt: halted, st: state,
                      cause: halt_cause, cnt: instr_cnt};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL cycle_%0d: got en=%b rst=%b hlt=%b st=%0d cause=%0d cnt=%0d expected en=%b rst=%b hlt=%b st=%0d cause=%0d cnt=%0d",
                             cyc_no, a.en, a.crst, a.hlt, a.st, a.cause, a.cnt,
                             e.en, e.crst, e.hlt, e.st, e.cause, e.cnt);
                end
            end
        end
    end

    initial begin
        bit s;
        // Reset: two clrn cycles then RST_CYCLES of core_rst
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        for (int i = 0; i < RSTC; i++) begin
            cyc(0, 0, 0, 0); settle(); chk("core_rst_hold", int'(core_rst), 1);
        end
        cyc(0, 0, 0, 0); settle();
        chk("rst_state", int'(state), 1);
        chk("rst_halted", int'(halted), 1);
        chk("rst_cpu_en", int'(cpu_en), 0);
        chk("rst_cnt", int'(instr_cnt), 0);
        chk("rst_cause", int'(halt_cause), 0);

        // Run then user halt after 10 commits
        cyc(0, 1, 0, 0); idle(10);
        cyc(0, 0, 1, 0); settle(); chk("uh_en_off", int'(cpu_en), 0);
        cyc(0, 0, 0, 0); settle();
        chk("uh_halted", int'(halted), 1);
        chk("uh_cause", int'(halt_cause), 1);
        chk("uh_cnt", int'(instr_cnt), 10);

        // Breakpoint at 0x10, resume past it, then step with pc==bp_addr
        do_reset(); bpe = 1; bpa = 32'h10;
        cyc(0, 1, 0, 0); idle(6); settle();
        chk("bp_cause", int'(halt_cause), 2);
        chk("bp_cnt", int'(instr_cnt), 4);
        cyc(0, 1, 0, 0); idle(4);
        cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); settle();
        chk("bp_resume_cnt", int'(instr_cnt), 8);
        bpa = 32'h20;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        idle(2); settle();
        chk("bp_step_cnt", int'(instr_cnt), 9);
        chk("bp_step_cause", int'(halt_cause), 0);
        bpe = 0;

        // Three held button presses
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
            idle(2); settle();
            chk("step_halted", int'(halted), 1);
        end
        chk("step_cnt", int'(instr_cnt), 3);
        // Button held through reset
        cyc(1, 0, 0, 1);
        for (int i = 0; i < RSTC + 4; i++) cyc(0, 0, 0, 1);
        idle(2); settle();
        chk("held_step_cnt", int'(instr_cnt), 0);

        // Halt instruction at 0x8 is sticky
        do_reset(); halt_on = 1; halt_pc = 32'h8;
        cyc(0, 1, 0, 0); idle(4); settle();
        chk("hi_cause", int'(halt_cause), 3);
        chk("hi_cnt", int'(instr_cnt), 2);
        cyc(0, 1, 0, 0); idle(3);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); idle(3); settle();
        chk("hi_sticky_cnt", int'(instr_cnt), 2);
        chk("hi_sticky_cause", int'(halt_cause), 3);
        halt_on = 0;

        // Saturation and reset mid-run
        do_reset();
        cyc(0, 1, 0, 0); idle(20); settle();
        chk("sat_cnt", int'(instr_cnt), 15);
        cyc(1, 0, 0, 0); settle(); chk("midrst_en", int'(cpu_en), 0);
        cyc(0, 0, 0, 0); settle();
        chk("midrst_core_rst", int'(core_rst), 1);
        chk("midrst_cnt", int'(instr_cnt), 0);

        // Randomized traffic
        do_reset();
        s = 0;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                bpe = $urandom_range(0, 1) == 1;
                bpa = 32'($urandom_range(0, 15)) * 4;
                halt_on = $urandom_range(0, 3) == 0;
                halt_pc = 32'($urandom_range(0, 15)) * 4;
            end
            if ($urandom_range(0, 2) == 0) s = !s;
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0, s);
        end
        idle(2);
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step/halt sequencer for the single-cycle CPU Datapath on the FPGA board.
- Drives the Datapath clock-enable and core reset, so the core can be free-run, single-stepped from a board button, stopped by breakpoint, or stopped by a halt instruction.
- Counts committed instructions for on-board display.
- Sits between board I/O (buttons/switches) and the Datapath's pc/inst outputs.

Parameters:
- PC_W, 32: width of pc and bp_addr.
- CNT_W, 32: width of instr_cnt.
- RST_CYCLES, 4: number of cycles core_rst is held after clrn deasserts (>=1).
- HALT_INST, 32'hFFFF_FFFF: instruction encoding that halts the core.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- clrn  in  1  synchronous, active-high reset.
- run_req  in  1  pulse; start continuous run.
- halt_req  in  1  pulse; user stop.
- step_req  in  1  level from synchronized step button; rising edge requests one instruction.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint PC.
- pc  in  PC_W  current PC from Datapath.
- inst  in  32  current instruction from Datapath.
- cpu_en  out  1  Datapath clock-enable; one instruction commits per cycle when high.
- core_rst  out  1  reset to Datapath.
- halted  out  1  high in HALTED state.
- state  out  2  0=RESET, 1=HALTED, 2=RUN, 3=STEP.
- halt_cause  out  2  0=none/step, 1=user, 2=breakpoint, 3=halt instruction.
- instr_cnt  out  CNT_W  committed-instruction count.

Behaviour:
- Reset values: when clrn=1 at a clock edge, next state is RESET, rst_cnt=0, instr_cnt=0, halt_cause=0, bp_skip=0, step_q=1.
  - step_q=1 at reset means a button already held across reset produces no step.
  - cpu_en is forced to 0 combinationally in any cycle where clrn=1.
- RESET: core_rst=1, cpu_en=0, halted=0. rst_cnt increments each cycle; when rst_cnt==RST_CYCLES-1, go to HALTED. core_rst is high for exactly RST_CYCLES cycles after clrn drops. Reset asserted mid-RUN or mid-STEP aborts immediately; no instruction commits in the clrn cycle.
- core_rst is registered: it is 1 in RESET and 0 in all other states.
- Step edge detect: step_q <= step_req every cycle; step_edge = step_req & ~step_q. Edges outside HALTED are discarded, not queued.
- Stop conditions, evaluated combinationally in the current cycle:
  - hi = (inst==HALT_INST)
  - bp = bp_en & (pc==bp_addr) & ~bp_skip
- HALTED:
  - cpu_en=0, halted=1.
  - halt_req keeps the block halted and overrides run_req and step in the same cycle.
  - Otherwise run_req goes to RUN; run_req has priority over step_edge.
  - Otherwise step_edge goes to STEP.
  - On leaving for RUN or STEP, set bp_skip=1 so a resume from a breakpoint executes the breakpoint instruction.
- RUN:
  - cpu_en = ~(hi | bp | halt_req).
  - Stop priority: hi gives cause 3, else bp gives cause 2, else halt_req gives cause 1. On any stop, next state is HALTED and the stopping instruction does not commit.
  - bp_skip clears after the first RUN cycle.
  - run_req in RUN is ignored.
- STEP:
  - Lasts one cycle; cpu_en = ~hi, and the breakpoint is ignored.
  - Next state is HALTED with cause 3 if hi, else 0.
  - bp_skip clears.
  - halt_req in STEP is ignored; the step still completes.
- Halt instruction is sticky: while inst==HALT_INST, both run_req and step yield zero cpu_en cycles and re-halt with cause 3. Only reset leaves it.
- instr_cnt increments by 1 on every edge where cpu_en=1 and saturates at 2^CNT_W-1. It holds in HALTED and clears only on reset.
- halt_cause is registered and updates only on entry to HALTED.
- state, halted, halt_cause and instr_cnt are registered. cpu_en is combinational from state and inputs.

Test Plan:
- Reset: clrn=1 for 2 cycles, then 0 → core_rst=1 for 4 cycles, then state=1, halted=1, cpu_en=0, instr_cnt=0, halt_cause=0.
- Run/user halt: bench PC model +4 per cpu_en from pc=0.
  - run_req pulse → cpu_en=1 from the next cycle.
  - halt_req after 10 enabled cycles → cpu_en=0 in that cycle, then halted=1, halt_cause=1, instr_cnt=10, pc=0x28.
- Breakpoint: bp_en=1, bp_addr=0x10, run from pc=0 → halt with pc=0x10, instr_cnt=4, halt_cause=2.
  - run_req again → 0x10 commits in the first cycle and the run continues past it.
  - pc==0x10 during a STEP does not stop the step.
- Step: three button presses, each held 5 cycles → exactly 3 cpu_en cycles, instr_cnt=3, halted=1 after each. A button held through reset gives 0 steps.
- Halt instruction: inst=HALT_INST when pc=0x8 → cpu_en=0, halt_cause=3, instr_cnt=2. A subsequent run_req and step each give zero cpu_en cycles.
- Saturation/reset mid-run: CNT_W=4, run 20 cycles → instr_cnt=15. Assert clrn mid-run → cpu_en=0 in that cycle, instr_cnt=0, core_rst=1 next cycle.
